// File: rtl/sync_fifo2.sv
// Single-clock FIFO with wrap-bit pointers, registered occupancy/flags, sticky
// overflow/underflow, and a choice of registered-read or first-word-fall-through output.
module sync_fifo2 #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  input  logic             clr_err,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] ONE    = (ASIZE+1)'(1);
  localparam logic [ASIZE:0] AF_LVL = (ASIZE+1)'(AF_THRESH);
  localparam logic [ASIZE:0] AE_LVL = (ASIZE+1)'(AE_THRESH);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr, rptr;
  logic [ASIZE:0]   wptr_nxt, rptr_nxt, count_nxt;
  logic             wr_ok, rd_ok;
  logic             full_nxt, empty_nxt;

  // Occupancy never leaves 0..DEPTH because acceptance already excludes
  // writing when full and reading when empty.
  function automatic logic [ASIZE:0] next_count(input logic [ASIZE:0] c,
                                                input logic w, input logic r);
    logic [ASIZE:0] n;
    n = c;
    if (w && !r)      n = c + ONE;
    else if (!w && r) n = c - ONE;
    return n;
  endfunction

  always_comb begin
    wr_ok     = winc & ~wfull;
    rd_ok     = rinc & ~rempty;
    wptr_nxt  = wr_ok ? wptr + ONE : wptr;
    rptr_nxt  = rd_ok ? rptr + ONE : rptr;
    count_nxt = next_count(count, wr_ok, rd_ok);
    full_nxt  = (wptr_nxt[ASIZE-1:0] == rptr_nxt[ASIZE-1:0]) &&
                (wptr_nxt[ASIZE] != rptr_nxt[ASIZE]);
    empty_nxt = (wptr_nxt == rptr_nxt);
  end

  // Storage is left out of reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[wptr[ASIZE-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      wfull         <= 1'b0;
      rempty        <= 1'b1;
      walmost_full  <= 1'b0;
      ralmost_empty <= 1'b1;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      wptr          <= wptr_nxt;
      rptr          <= rptr_nxt;
      count         <= count_nxt;
      wfull         <= full_nxt;
      rempty        <= empty_nxt;
      walmost_full  <= (count_nxt >= AF_LVL);
      ralmost_empty <= (count_nxt <= AE_LVL);
      // A fresh error in the clearing cycle must win over the clear.
      overflow      <= (overflow  & ~clr_err) | (winc & wfull);
      underflow     <= (underflow & ~clr_err) | (rinc & rempty);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = rempty ? '0 : mem[rptr[ASIZE-1:0]];
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (rst)        rdata <= '0;
        else if (rd_ok) rdata <= mem[rptr[ASIZE-1:0]];
      end
    end
  endgenerate

endmodule
